// File: rtl/gate_vector_checker_if.sv
// gate_vector_checker_if: beat intake, per-beat results and statistics of the gate-vector checker
interface gate_vector_checker_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [9:0]       y_in;
  logic             out_valid;
  logic             a_out;
  logic             b_out;
  logic             match;
  logic [9:0]       err_bits;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             err_sticky;
  logic [9:0]       first_err_vec;
  modport master (
    output in_valid, y_in,
    input  in_ready, out_valid, a_out, b_out, match, err_bits, vec_cnt, err_cnt, err_sticky, first_err_vec
  );
  modport slave (
    input  in_valid, y_in,
    output in_ready, out_valid, a_out, b_out, match, err_bits, vec_cnt, err_cnt, err_sticky, first_err_vec
  );
endinterface

// File: rtl/gate_vector_checker.sv
// gate_vector_checker: recovers a/b from gate result vectors, flags mismatching bits, keeps error stats
module gate_vector_checker #(
  parameter int CNT_W       = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  clr,
  gate_vector_checker_if.slave bus
);
  typedef enum logic {RUN, HALT} state_t;
  state_t     state, state_nx;
  logic       s1_v, a, b, mm, acc;
  logic [9:0] s1_y, exp_y, err;
  always_comb begin
    a            = s1_y[8];
    b            = s1_y[9];
    exp_y        = {b, a, ~b, ~a, ~(a ^ b), ~(a | b), ~(a & b), a ^ b, a | b, a & b};
    err          = s1_y ^ exp_y;
    mm           = |err;
    bus.in_ready = (state == RUN) & ~clr & ~rst;
    acc          = bus.in_valid & bus.in_ready;
    state_nx     = clr ? RUN : (state == RUN && s1_v && mm && STOP_ON_ERR) ? HALT : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else     state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v              <= 1'b0;
      s1_y              <= '0;
      bus.out_valid     <= 1'b0;
      bus.a_out         <= 1'b0;
      bus.b_out         <= 1'b0;
      bus.match         <= 1'b0;
      bus.err_bits      <= '0;
      bus.vec_cnt       <= '0;
      bus.err_cnt       <= '0;
      bus.err_sticky    <= 1'b0;
      bus.first_err_vec <= '0;
    end else if (clr) begin
      s1_v              <= 1'b0;
      s1_y              <= '0;
      bus.out_valid     <= 1'b0;
      bus.a_out         <= 1'b0;
      bus.b_out         <= 1'b0;
      bus.match         <= 1'b0;
      bus.err_bits      <= '0;
      bus.vec_cnt       <= '0;
      bus.err_cnt       <= '0;
      bus.err_sticky    <= 1'b0;
      bus.first_err_vec <= '0;
    end else begin
      s1_v          <= acc;
      bus.out_valid <= s1_v;
      if (acc) s1_y <= bus.y_in;
      if (s1_v) begin
        bus.a_out    <= a;
        bus.b_out    <= b;
        bus.match    <= ~mm;
        bus.err_bits <= err;
        bus.vec_cnt  <= (&bus.vec_cnt) ? bus.vec_cnt : bus.vec_cnt + CNT_W'(1);
        if (mm) begin
          bus.err_cnt <= (&bus.err_cnt) ? bus.err_cnt : bus.err_cnt + CNT_W'(1);
          if (!bus.err_sticky) begin
            bus.err_sticky    <= 1'b1;
            bus.first_err_vec <= s1_y;
          end
        end
      end
    end
  end
endmodule
